// File: rtl/vga_sprite_render_pkg.sv
// Shared VGA 640x480 timing constants, colour type and position-latch state
// encoding for the sprite renderer slice.
package vga_sprite_render_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;
    localparam int RGB_W     = 12;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic {
        POS_IDLE,
        POS_PENDING
    } pos_state_t;

    function automatic logic [9:0] clamp_pos(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/vga_pos_latch.sv
// Position request handshake: one clamped request is held in shadow registers
// and moved to the active position only at the frame latch event.
module vga_pos_latch
    import vga_sprite_render_pkg::*;
#(
    parameter int unsigned SPR_W  = 32,
    parameter int unsigned SPR_H  = 32,
    parameter int unsigned INIT_X = 304,
    parameter int unsigned INIT_Y = 224
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       pos_valid,
    output logic       pos_ready,
    input  logic       latch,
    output logic [9:0] act_x,
    output logic [9:0] act_y
);

    localparam logic [9:0] X_MAX = 10'(H_VISIBLE - int'(SPR_W));
    localparam logic [9:0] Y_MAX = 10'(V_VISIBLE - int'(SPR_H));

    pos_state_t state_q, state_d;
    logic       accept;
    logic       apply;
    logic [9:0] shadow_x, shadow_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= POS_IDLE;
        else        state_q <= state_d;
    end

    // A request accepted on the latch cycle itself starts a new pending period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            POS_IDLE:    if (accept) state_d = POS_PENDING;
            POS_PENDING: if (latch)  state_d = POS_IDLE;
            default:     state_d = POS_IDLE;
        endcase
    end

    always_comb begin
        pos_ready = (state_q == POS_IDLE);
        accept    = pos_valid && (state_q == POS_IDLE);
        apply     = latch && (state_q == POS_PENDING);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_x <= 10'(INIT_X);
            shadow_y <= 10'(INIT_Y);
            act_x    <= 10'(INIT_X);
            act_y    <= 10'(INIT_Y);
        end else begin
            if (accept) begin
                shadow_x <= clamp_pos(pos_x, X_MAX);
                shadow_y <= clamp_pos(pos_y, Y_MAX);
            end
            if (apply) begin
                act_x <= shadow_x;
                act_y <= shadow_y;
            end
        end
    end

endmodule

// File: rtl/vga_sprite_render.sv
// Overlays one ROM-backed sprite on a flat background; two-stage pixel
// pipeline with syncs realigned to the registered RGB.
module vga_sprite_render
    import vga_sprite_render_pkg::*;
#(
    parameter int unsigned SPR_W     = 32,
    parameter int unsigned SPR_H     = 32,
    parameter logic [11:0] BG_COLOR  = 12'h024,
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    parameter int unsigned INIT_X    = 304,
    parameter int unsigned INIT_Y    = 224
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [9:0]                         hcnt,
    input  logic [9:0]                         vcnt,
    input  logic                               video_on,
    input  logic                               hsync_in,
    input  logic                               vsync_in,
    input  logic [9:0]                         pos_x,
    input  logic [9:0]                         pos_y,
    input  logic                               pos_valid,
    output logic                               pos_ready,
    output logic [$clog2(SPR_W*SPR_H)-1:0]     rom_addr,
    input  logic [11:0]                        rom_data,
    output logic [3:0]                         vga_r,
    output logic [3:0]                         vga_g,
    output logic [3:0]                         vga_b,
    output logic                               hsync_out,
    output logic                               vsync_out,
    output logic                               frame_tick,
    output logic [7:0]                         frame_cnt
);

    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);

    logic [9:0]  act_x, act_y;
    logic [10:0] dx, dy;
    logic        hit, latch;
    logic        hit_q, von_q;
    rgb_t        rgb_d, rgb_q;

    assign latch = (vcnt == 10'(V_VISIBLE)) && (hcnt == '0);

    vga_pos_latch #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .INIT_X (INIT_X),
        .INIT_Y (INIT_Y)
    ) u_pos_latch (
        .clk       (clk),
        .reset     (reset),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .latch     (latch),
        .act_x     (act_x),
        .act_y     (act_y)
    );

    // 11-bit offsets so act+SPR_W never wraps back into column/line 0.
    always_comb begin
        dx  = {1'b0, hcnt} - {1'b0, act_x};
        dy  = {1'b0, vcnt} - {1'b0, act_y};
        hit = (hcnt >= act_x) && (dx < 11'(SPR_W)) &&
              (vcnt >= act_y) && (dy < 11'(SPR_H));
        rom_addr = hit ? {dy[YW-1:0], dx[XW-1:0]} : '0;
    end

    always_comb begin
        if (!von_q)                             rgb_d = '0;
        else if (hit_q && rom_data != KEY_COLOR) rgb_d = rom_data;
        else                                    rgb_d = BG_COLOR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q      <= 1'b0;
            von_q      <= 1'b0;
            rgb_q      <= '0;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            hit_q      <= hit;
            von_q      <= video_on;
            rgb_q      <= rgb_d;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            frame_tick <= latch;
            if (latch) frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign vga_r = rgb_q[11:8];
    assign vga_g = rgb_q[7:4];
    assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_vga_sprite_render.sv
// Directed plus randomized check of vga_sprite_render against a behavioural
// model of sprite position, handshake and pixel colour rules.
module tb_vga_sprite_render;

    localparam int SW  = 32;
    localparam int SH  = 32;
    localparam int BG  = 12'h024;
    localparam int KEY = 12'hF0F;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hcnt, vcnt;
    logic       video_on, hsync_in, vsync_in;
    logic [9:0] pos_x, pos_y;
    logic       pos_valid, pos_ready;
    logic [9:0] rom_addr;
    logic [11:0] rom_data;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       hsync_out, vsync_out, frame_tick;
    logic [7:0] frame_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    int m_ax, m_ay, m_sx, m_sy, m_fcnt;
    bit m_pend;

    vga_sprite_render #(
        .SPR_W     (SW),
        .SPR_H     (SH),
        .BG_COLOR  (12'h024),
        .KEY_COLOR (12'hF0F),
        .INIT_X    (304),
        .INIT_Y    (224)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    always #20 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_box(input int x, input int y);
        return x >= m_ax && x < m_ax + SW && y >= m_ay && y < m_ay + SH;
    endfunction

    function automatic int exp_addr(input int x, input int y);
        return in_box(x, y) ? (y - m_ay) * SW + (x - m_ax) : 0;
    endfunction

    function automatic int exp_rgb(input int x, input int y, input int rd);
        if (!(x < 640 && y < 480)) return 0;
        if (in_box(x, y) && rd != KEY) return rd;
        return BG;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_ax = 304; m_ay = 224; m_sx = 304; m_sy = 224;
        m_pend = 1'b0; m_fcnt = 0;
    endtask

    task automatic pixel(input string tag, input int x, input int y, input int rd);
        hcnt = 10'(x); vcnt = 10'(y); video_on = (x < 640 && y < 480);
        #1;
        chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr(x, y)));
        step();
        rom_data = 12'(rd);
        step();
        chk({tag, ".rgb"}, 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb(x, y, rd)));
    endtask

    task automatic rand_pixels(input int n);
        int x, y, rd;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                x = m_ax + int'($urandom_range(SW - 1, 0));
                y = m_ay + int'($urandom_range(SH - 1, 0));
            end else begin
                x = int'($urandom_range(799, 0));
                y = int'($urandom_range(479, 0));
            end
            rd = ($urandom_range(3, 0) == 0) ? KEY : int'($urandom_range(4095, 0));
            pixel("rand", x, y, rd);
        end
    endtask

    task automatic do_latch(input string tag);
        hcnt = 10'd0; vcnt = 10'd480; video_on = 1'b0;
        step();
        if (m_pend) begin
            m_ax = m_sx; m_ay = m_sy; m_pend = 1'b0;
        end
        m_fcnt = (m_fcnt + 1) % 256;
        chk({tag, ".tick"}, 32'(frame_tick), 32'd1);
        chk({tag, ".cnt"}, 32'(frame_cnt), 32'(m_fcnt));
        hcnt = 10'd1;
        step();
        chk({tag, ".tick_off"}, 32'(frame_tick), 32'd0);
    endtask

    task automatic request(input string tag, input int x, input int y);
        hcnt = 10'd5; vcnt = 10'd10; video_on = 1'b1;
        #1;
        chk({tag, ".ready_pre"}, 32'(pos_ready), 32'(!m_pend));
        pos_x = 10'(x); pos_y = 10'(y); pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
        if (!m_pend) begin
            m_sx = imin(x, 640 - SW); m_sy = imin(y, 480 - SH); m_pend = 1'b1;
        end
        chk({tag, ".ready_post"}, 32'(pos_ready), 32'd0);
    endtask

    initial begin
        reset = 1'b0; hcnt = '0; vcnt = '0; video_on = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        pos_x = '0; pos_y = '0; pos_valid = 1'b0; rom_data = '0;
        model_reset();
        repeat (3) step();
        chk("rst.rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst.hsync", 32'(hsync_out), 32'd1);
        chk("rst.vsync", 32'(vsync_out), 32'd1);
        chk("rst.tick", 32'(frame_tick), 32'd0);
        chk("rst.cnt", 32'(frame_cnt), 32'd0);
        chk("rst.ready", 32'(pos_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        step();

        pixel("corner_hit", 304, 224, 12'hABC);
        pixel("left_miss", 303, 224, 12'hABC);
        pixel("right_miss", 336, 224, 12'hABC);
        pixel("key", 310, 230, KEY);
        pixel("blank", 650, 100, 12'h777);

        hsync_in = 1'b0; step();
        chk("hsync_low", 32'(hsync_out), 32'd0);
        hsync_in = 1'b1; vsync_in = 1'b0; step();
        chk("hsync_high", 32'(hsync_out), 32'd1);
        chk("vsync_low", 32'(vsync_out), 32'd0);
        vsync_in = 1'b1; step();
        chk("vsync_high", 32'(vsync_out), 32'd1);

        rand_pixels(30);

        request("req100", 100, 50);
        pixel("pre_latch_old", 304, 224, 12'h123);
        pixel("pre_latch_new", 100, 50, 12'h456);
        do_latch("latch1");
        pixel("post_latch_new", 100, 50, 12'h456);
        pixel("post_latch_old", 304, 224, 12'h123);
        rand_pixels(20);

        request("req_clamp", 700, 470);
        do_latch("latch2");
        pixel("clamp_br", 639, 479, 12'h9E1);
        pixel("clamp_tl", 608, 448, 12'h5A5);
        pixel("no_wrap", 0, 0, 12'h5A5);
        pixel("no_wrap_v", 620, 0, 12'h5A5);

        hcnt = 10'd0; vcnt = 10'd480; video_on = 1'b0;
        pos_x = 10'd20; pos_y = 10'd30; pos_valid = 1'b1;
        step();
        pos_valid = 1'b0;
        m_fcnt = (m_fcnt + 1) % 256;
        m_sx = 20; m_sy = 30; m_pend = 1'b1;
        chk("latch_acc.tick", 32'(frame_tick), 32'd1);
        chk("latch_acc.ready", 32'(pos_ready), 32'd0);
        pixel("latch_acc_old", 620, 460, 12'h321);
        do_latch("latch3");
        pixel("latch_acc_new", 20, 30, 12'h321);

        for (int k = 0; k < 6; k++) begin
            request("rand_req", int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)));
            rand_pixels(8);
            do_latch("rand_latch");
            rand_pixels(8);
        end

        request("rst_req", 100, 100);
        hsync_in = 1'b0;
        pixel("pre_rst", m_ax, m_ay, 12'hFFF);
        chk("pre_rst.hsync", 32'(hsync_out), 32'd0);
        vcnt = 10'd200;
        #5;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst.rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("mid_rst.hsync", 32'(hsync_out), 32'd1);
        chk("mid_rst.vsync", 32'(vsync_out), 32'd1);
        chk("mid_rst.tick", 32'(frame_tick), 32'd0);
        chk("mid_rst.cnt", 32'(frame_cnt), 32'd0);
        chk("mid_rst.ready", 32'(pos_ready), 32'd1);
        hsync_in = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        step();
        pixel("post_rst", 304, 224, 12'hABC);
        do_latch("post_rst_latch");
        pixel("dropped_req", 100, 100, 12'hABC);
        pixel("kept_init", 335, 255, 12'hABC);

        for (int k = 0; k < 256; k++) begin
            hcnt = 10'd0; vcnt = 10'd480; video_on = 1'b0;
            step();
            m_fcnt = (m_fcnt + 1) % 256;
            hcnt = 10'd1;
            step();
        end
        chk("cnt_wrap", 32'(frame_cnt), 32'(m_fcnt));
        do_latch("wrap_latch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sprite_render.md
VGA_SPRITE_RENDER -- requirements
Module: vga_sprite_render

Interface
REQ-001 Parameter SPR_W, default 32, sprite width in pixels (power of two).
REQ-002 Parameter SPR_H, default 32, sprite height in lines (power of two).
REQ-003 Parameter BG_COLOR, default 12'h024, background RGB444.
REQ-004 Parameter KEY_COLOR, default 12'hF0F, transparent texel value.
REQ-005 Parameters INIT_X / INIT_Y, default 304 / 224, sprite position after reset.
REQ-006 clk  in  1  25 MHz pixel clock; the only clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 hcnt  in  10  horizontal pixel counter, 0..799, from the sync generator.
REQ-009 vcnt  in  10  vertical line counter, 0..524, from the sync generator.
REQ-010 video_on  in  1  visible-region flag, aligned with hcnt/vcnt.
REQ-011 hsync_in / vsync_in  in  1 each  active-low syncs, registered one cycle after hcnt/vcnt.
REQ-012 pos_x / pos_y  in  10 each  requested sprite top-left corner.
REQ-013 pos_valid  in  1  position request valid.
REQ-014 pos_ready  out  1  position request accepted when high with pos_valid.
REQ-015 rom_addr  out  log2(SPR_W*SPR_H)  sprite ROM address, combinational from hcnt/vcnt.
REQ-016 rom_data  in  12  sprite texel, valid one cycle after rom_addr.
REQ-017 vga_r / vga_g / vga_b  out  4 each  registered pixel colour.
REQ-018 hsync_out / vsync_out  out  1 each  syncs realigned to RGB.
REQ-019 frame_tick  out  1  one-cycle pulse at frame latch.
REQ-020 frame_cnt  out  8  frame counter, incremented per frame_tick, wraps 255->0.

Function
REQ-021 Sprite hit when act_x <= hcnt < act_x+SPR_W and act_y <= vcnt < act_y+SPR_H.
REQ-022 On hit, rom_addr = {vcnt-act_y, hcnt-act_x} (row-major); otherwise rom_addr = 0.
REQ-023 Pipeline: stage 1 registers hit and video_on; stage 2 registers RGB from rom_data; RGB for hcnt=N appears 2 cycles after hcnt=N.
REQ-024 hsync_out/vsync_out = hsync_in/vsync_in delayed one cycle, so total sync latency matches RGB.
REQ-025 RGB selection: delayed video_on=0 -> 12'h000; else hit and rom_data != KEY_COLOR -> rom_data; else BG_COLOR.
REQ-026 Handshake: pending flag; pos_ready = !pending; accept on pos_valid && pos_ready -> shadow regs load, pending=1.
REQ-027 On accept, pos_x clamps to 640-SPR_W and pos_y clamps to 480-SPR_H if exceeded.
REQ-028 Latch event: the cycle with vcnt==480 and hcnt==0 (first vblank pixel).
REQ-029 At latch: if pending, act_x/act_y <- shadow and pending <- 0; frame_tick=1 regardless; frame_cnt += 1.
REQ-030 Accept on latch cycle (pending was 0): value goes to shadow only, applied at next latch.
REQ-031 Active position never changes outside latch event; no tearing within a visible frame.
REQ-032 Sprite at right/bottom clamp edge draws fully; no wrap into column 0 or line 0.

Reset
REQ-033 While reset low: vga_r/g/b=0, hsync_out=1, vsync_out=1, frame_tick=0, frame_cnt=0, pos_ready=1, pending=0.
REQ-034 Reset loads act_x=INIT_X, act_y=INIT_Y; shadow registers cleared to the same values.
REQ-035 Reset asserted mid-frame takes effect immediately (async); any pending request is dropped.
REQ-036 After release, RGB valid from the 2nd clock; no state beyond the pipeline requires a flush.

Structure
REQ-037 Shared package holds H_VISIBLE=640, V_VISIBLE=480, H_TOTAL=800, V_TOTAL=525, and the RGB444 colour width.
REQ-038 Sprite ROM stays outside this block; no sub-module is required; the handshake/shadow logic may be split out as vga_pos_latch.

Verification
REQ-039 Reset release, act=(304,224), pixel (304,224), rom_data=12'hABC -> RGB A/B/C exactly 2 cycles after hcnt=304; rom_addr=0.
REQ-040 Pixel (303,224) or (336,224), and rom_data=KEY_COLOR inside sprite -> RGB=12'h024.
REQ-041 hcnt=650, video_on=0 -> RGB=0; hsync_in low at hcnt 656..751 -> hsync_out low exactly 1 cycle later.
REQ-042 pos=(100,50) at vcnt=10 -> pos_ready low; sprite unchanged until latch; next frame hit at (100,50); frame_tick once; frame_cnt+1.
REQ-043 pos=(700,470) -> act=(608,448) after latch; pixel (639,479) hit with rom_addr=1023.
REQ-044 Reset low at vcnt=200 with pending request -> outputs per REQ-033; after release, position = (304,224).
